// File: rtl/ycr_arbn.sv
// N-way round-robin arbiter with registered grant, burst hold, lock and ack watchdog.
// Grant is held until ack or timeout; a release always costs one idle ARB cycle.
module ycr_arbn #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned NW      = $clog2(NREQ),
   parameter int unsigned BURST_W = 4,
   parameter int unsigned TMO_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic               ack,
   input  logic               lock,
   input  logic [BURST_W-1:0] burst_max,
   input  logic [TMO_W-1:0]   tmo_cycles,
   output logic               gnt_vld,
   output logic [NW-1:0]      gnt_id,
   output logic [NREQ-1:0]    gnt_oh,
   output logic               tmo_err
);

   typedef enum logic [0:0] {StArb, StWaitAck} state_e;

   state_e             state_q, state_d;
   logic [NW-1:0]      ptr_q, ptr_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic               gnt_vld_q, gnt_vld_d;
   logic [NW-1:0]      gnt_id_q, gnt_id_d;
   logic [NREQ-1:0]    gnt_oh_q, gnt_oh_d;
   logic               tmo_err_q, tmo_err_d;

   logic               win_found;
   logic [NW-1:0]      win_id;
   logic [NW-1:0]      scan_idx;
   logic [BURST_W:0]   burst_inc;
   logic [BURST_W-1:0] burst_lim;
   logic [BURST_W-1:0] burst_sat;
   logic               keep;
   logic               tmo_hit;
   logic [NW-1:0]      ptr_nxt;

   // Rotating priority scan: first requester at or after ptr (mod NREQ) wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         scan_idx = NW'((32'(ptr_q) + i) % NREQ);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   always_comb begin
      burst_inc = {1'b0, burst_cnt_q} + 1'b1;
      burst_lim = (burst_max == '0) ? BURST_W'(1) : burst_max;
      burst_sat = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + 1'b1;
      keep      = req[gnt_id_q] && (lock || (burst_inc < {1'b0, burst_lim}));
      tmo_hit   = (tmo_cycles != '0) && (tmo_cnt_q == tmo_cycles - 1'b1);
      ptr_nxt   = (gnt_id_q == NW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      burst_cnt_d = burst_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      gnt_vld_d   = gnt_vld_q;
      gnt_id_d    = gnt_id_q;
      gnt_oh_d    = gnt_oh_q;
      tmo_err_d   = 1'b0;
      unique case (state_q)
         StArb: begin
            if (win_found) begin
               state_d     = StWaitAck;
               gnt_vld_d   = 1'b1;
               gnt_id_d    = win_id;
               gnt_oh_d    = NREQ'(1) << win_id;
               burst_cnt_d = '0;
               tmo_cnt_d   = '0;
            end
         end
         StWaitAck: begin
            if (ack || tmo_hit) begin
               // ack takes priority over a coincident timeout
               tmo_cnt_d   = '0;
               burst_cnt_d = burst_sat;
               if (ack && keep) begin
                  state_d = StWaitAck;
               end else begin
                  state_d     = StArb;
                  gnt_vld_d   = 1'b0;
                  gnt_oh_d    = '0;
                  ptr_d       = ptr_nxt;
                  burst_cnt_d = '0;
                  tmo_err_d   = !ack;
               end
            end else if ((tmo_cycles != '0) && !(&tmo_cnt_q)) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         default: state_d = StArb;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StArb;
         ptr_q       <= '0;
         burst_cnt_q <= '0;
         tmo_cnt_q   <= '0;
         gnt_vld_q   <= 1'b0;
         gnt_id_q    <= '0;
         gnt_oh_q    <= '0;
         tmo_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         burst_cnt_q <= burst_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         gnt_vld_q   <= gnt_vld_d;
         gnt_id_q    <= gnt_id_d;
         gnt_oh_q    <= gnt_oh_d;
         tmo_err_q   <= tmo_err_d;
      end
   end

   assign gnt_vld = gnt_vld_q;
   assign gnt_id  = gnt_id_q;
   assign gnt_oh  = gnt_oh_q;
   assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_ycr_arbn.sv
// Directed bench for ycr_arbn: per-cycle expected grant state queued as a scoreboard.
module tb_ycr_arbn;

   localparam int NREQ    = 4;
   localparam int NW      = 2;
   localparam int BURST_W = 4;
   localparam int TMO_W   = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic               ack;
   logic               lock;
   logic [BURST_W-1:0] burst_max;
   logic [TMO_W-1:0]   tmo_cycles;
   logic               gnt_vld;
   logic [NW-1:0]      gnt_id;
   logic [NREQ-1:0]    gnt_oh;
   logic               tmo_err;

   ycr_arbn #(
      .NREQ    (NREQ),
      .BURST_W (BURST_W),
      .TMO_W   (TMO_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .ack        (ack),
      .lock       (lock),
      .burst_max  (burst_max),
      .tmo_cycles (tmo_cycles),
      .gnt_vld    (gnt_vld),
      .gnt_id     (gnt_id),
      .gnt_oh     (gnt_oh),
      .tmo_err    (tmo_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          vld;
      logic [NW-1:0] id;
      logic          tmo;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string tag, input string what, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic v, input int id, input logic t);
      exp_t e;
      e.vld = v;
      e.id  = NW'(id);
      e.tmo = t;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_out();
      exp_t          e;
      string         tag;
      logic [NREQ-1:0] oh;
      e   = sb_q.pop_front();
      tag = tag_q.pop_front();
      oh  = e.vld ? (NREQ'(1) << e.id) : '0;
      chk(tag, "gnt_vld", 32'(gnt_vld), 32'(e.vld));
      chk(tag, "gnt_id", 32'(gnt_id), 32'(e.id));
      chk(tag, "gnt_oh", 32'(gnt_oh), 32'(oh));
      chk(tag, "tmo_err", 32'(tmo_err), 32'(e.tmo));
   endtask

   // Drive ack for one clock edge and check the registered result just after it.
   task automatic cyc(input string tag, input logic a, input logic v, input int id,
                      input logic t);
      ack = a;
      push_exp(tag, v, id, t);
      @(posedge clk);
      #1;
      check_out();
   endtask

   // Async reset mid-cycle; outputs must go idle without a clock edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      ack = 1'b0;
      rst = 1'b1;
      #1;
      push_exp(tag, 1'b0, 0, 1'b0);
      check_out();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst        = 1'b1;
      req        = '0;
      ack        = 1'b0;
      lock       = 1'b0;
      burst_max  = 4'd1;
      tmo_cycles = '0;
      #12;
      push_exp("reset", 1'b0, 0, 1'b0);
      check_out();
      @(negedge clk);
      rst = 1'b0;

      // Round robin with burst_max=1: 0,1,2,3,0 each separated by one idle cycle.
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         cyc("rr_gnt", 1'b0, 1'b1, k % 4, 1'b0);
         cyc("rr_rel", 1'b1, 1'b0, k % 4, 1'b0);
      end

      // Burst of 3 acks to requester 0, then rotation to 2.
      do_reset("rst2");
      req       = 4'b0101;
      burst_max = 4'd3;
      cyc("bu_gnt", 1'b0, 1'b1, 0, 1'b0);
      cyc("bu_ack1", 1'b1, 1'b1, 0, 1'b0);
      cyc("bu_ack2", 1'b1, 1'b1, 0, 1'b0);
      cyc("bu_ack3", 1'b1, 1'b0, 0, 1'b0);
      cyc("bu_next", 1'b1, 1'b1, 2, 1'b0);
      req = 4'b0000;
      cyc("bu_rel2", 1'b1, 1'b0, 2, 1'b0);

      // Lock holds past burst_max; dropping req releases. ptr=3 -> grant 0.
      req       = 4'b0011;
      burst_max = 4'd2;
      lock      = 1'b1;
      cyc("lk_gnt", 1'b0, 1'b1, 0, 1'b0);
      for (int k = 0; k < 10; k++) cyc("lk_hold", 1'b1, 1'b1, 0, 1'b0);
      req = 4'b0010;
      cyc("lk_rel", 1'b1, 1'b0, 0, 1'b0);
      cyc("lk_next", 1'b0, 1'b1, 1, 1'b0);
      req  = 4'b0000;
      lock = 1'b0;
      cyc("lk_rel1", 1'b1, 1'b0, 1, 1'b0);

      // Watchdog of 5 cycles on grant to 1 (ptr=2); grant held despite req changes.
      tmo_cycles = 8'd5;
      req        = 4'b0010;
      cyc("to_gnt", 1'b0, 1'b1, 1, 1'b0);
      req = 4'b0110;
      for (int k = 0; k < 4; k++) cyc("to_wait", 1'b0, 1'b1, 1, 1'b0);
      cyc("to_fire", 1'b0, 1'b0, 1, 1'b1);
      cyc("to_next", 1'b0, 1'b1, 2, 1'b0);
      tmo_cycles = 8'd0;
      for (int k = 0; k < 20; k++) cyc("to_off", 1'b0, 1'b1, 2, 1'b0);
      req = 4'b0000;
      cyc("to_rel", 1'b1, 1'b0, 2, 1'b0);

      // ack coincident with timeout releases without tmo_err; ack in ARB ignored.
      tmo_cycles = 8'd3;
      burst_max  = 4'd1;
      req        = 4'b1000;
      cyc("co_gnt", 1'b0, 1'b1, 3, 1'b0);
      cyc("co_w1", 1'b0, 1'b1, 3, 1'b0);
      cyc("co_w2", 1'b0, 1'b1, 3, 1'b0);
      req = 4'b0000;
      cyc("co_ack", 1'b1, 1'b0, 3, 1'b0);
      cyc("arb_ack1", 1'b1, 1'b0, 3, 1'b0);
      cyc("arb_ack2", 1'b1, 1'b0, 3, 1'b0);
      req = 4'b0100;
      cyc("co_next", 1'b0, 1'b1, 2, 1'b0);
      req = 4'b0000;
      cyc("co_rel", 1'b1, 1'b0, 2, 1'b0);
      tmo_cycles = 8'd0;

      // Reset mid-burst (burst_cnt=2); ptr returns to 0 so 1010 grants 1.
      burst_max = 4'd4;
      req       = 4'b0001;
      cyc("rs_gnt", 1'b0, 1'b1, 0, 1'b0);
      cyc("rs_ack1", 1'b1, 1'b1, 0, 1'b0);
      cyc("rs_ack2", 1'b1, 1'b1, 0, 1'b0);
      req = 4'b1010;
      do_reset("rs_async");
      cyc("rs_first", 1'b0, 1'b1, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ycr_arbn.md
# ycr_arbn

Parametrised N-way round-robin arbiter with registered grant and ack handshake, the multi-requester successor to the two-port core-interface arbiter. It adds burst hold (back-to-back grants to one requester up to a programmable count), a lock input for atomic sequences, and an ack watchdog that reclaims a stuck grant. It sits between the core-side requesters (IMEM, DMEM, debug, DMA) and a shared memory/wishbone port.

## Interface
- NREQ, 4: number of requesters, 2..16
- NW, $clog2(NREQ): grant index width (derived, not overridden)
- BURST_W, 4: width of burst_max and of the internal burst counter
- TMO_W, 8: width of tmo_cycles and of the watchdog counter

- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req  in  NREQ  request vector, bit i = requester i
- ack  in  1  one-cycle transfer-complete pulse from the shared slave
- lock  in  1  sampled with ack: hold the current grant while the owner's req stays high
- burst_max  in  BURST_W  max acks per grant before forced rotation; 0 treated as 1
- tmo_cycles  in  TMO_W  watchdog limit in cycles; 0 disables
- gnt_vld  out  1  grant valid
- gnt_id  out  NW  granted requester index
- gnt_oh  out  NREQ  one-hot grant, all-zero when gnt_vld=0
- tmo_err  out  1  one-cycle pulse when the watchdog reclaims a grant

## Operation
- States: ARB, WAIT_ACK. Reset: state=ARB, gnt_vld=0, gnt_id=0, gnt_oh=0, tmo_err=0, ptr=0, burst_cnt=0, tmo_cnt=0.
- ptr = highest-priority index. In ARB, scan req from ptr upward, wrapping mod NREQ; first set bit wins. No req: stay in ARB, outputs stay idle.
- Winner w: register gnt_vld=1, gnt_id=w, gnt_oh=1<<w; go to WAIT_ACK; burst_cnt=0, tmo_cnt=0.
- WAIT_ACK: grant held regardless of req changes until ack or timeout.
- On ack: burst_cnt increments (saturating at 2^BURST_W-1), tmo_cnt cleared. Then:
  - keep grant if req[w]=1 and (lock=1 or burst_cnt+1 < max(burst_max,1)); stay in WAIT_ACK, gnt outputs unchanged.
  - otherwise release: gnt_vld=0, gnt_oh=0 next cycle, ptr=(w+1) mod NREQ, state=ARB, burst_cnt=0.
- lock overrides burst_max; lock with req[w]=0 releases normally.
- Watchdog: with tmo_cycles≠0, tmo_cnt increments each WAIT_ACK cycle without ack. When tmo_cnt==tmo_cycles-1 and ack=0: release as above, ptr=(w+1) mod NREQ, tmo_err=1 for one cycle. tmo_cnt saturates; no wrap.
- gnt_id retains last value while gnt_vld=0; only gnt_oh and gnt_vld are cleared.
- Changes to burst_max/tmo_cycles take effect on the next comparison; no shadowing.

## Timing
- All outputs registered. req high in ARB at cycle t -> gnt_vld=1 at t+1.
- ack at t with release -> gnt_vld=0 at t+1; arbitration at t+1; next grant at t+2 (one idle cycle between owners, fixed).
- ack at t with keep -> gnt stays asserted with no gap.
- ack and timeout in the same cycle: ack wins, no tmo_err.
- ack while in ARB (gnt_vld=0): ignored, no state change.
- rst asserted mid-grant: outputs idle immediately (async), ptr=0; first grant after release follows ARB rules.
- tmo_err asserted exactly in the cycle gnt_vld falls.

## Test plan
- Reset, NREQ=4, req=4'b1111, burst_max=1, ack every grant -> grant order 0,1,2,3,0; each grant one cycle after entering ARB; one idle cycle between grants.
- req=4'b0101, burst_max=3, req[0] held, ack every cycle -> requester 0 gets 3 acks back-to-back with gnt_vld continuously high, then gnt_vld=0 for one cycle, then gnt_id=2.
- lock=1 with req[0] held for 10 acks, burst_max=2 -> no rotation for 10 acks; drop req[0] and ack -> release, next gnt_id=1 if req[1]=1.
- tmo_cycles=5, grant to 1, no ack -> gnt_vld falls and tmo_err pulses 5 cycles after grant; next grant goes to 2 (ptr=2); with tmo_cycles=0 grant held indefinitely.
- ack coincident with timeout cycle -> normal release, tmo_err stays 0; ack in ARB -> no effect.
- rst asserted during WAIT_ACK with burst_cnt=2 -> gnt_vld/gnt_oh/tmo_err=0 immediately; after rst release with req=4'b1010, first grant is 1.
